fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
// Sequences instruction_memory_pc: drives its PCSrc/immediate each cycle to advance, hold or branch the PC.
// Registers the fetched 24-bit instr into a one-entry slot with a valid/ready handshake toward decode.
// Resolves BR/BZ/HALT opcodes locally; BZ stalls the PC until execute reports the zero flag.
// Memory contract: PC updates on rising CLK; PCSrc=0 -> PC+1; PCSrc=1 -> PC+sext(immediate); instr=mem[PC] combinational.
// PARAMETERS
// IW       24     instruction width
// IMM_W    8      branch offset width, instr[IMM_W-1:0]
// OPC_BR   4'hA   unconditional relative branch, opcode=instr[IW-1:IW-4]
// OPC_BZ   4'hB   branch if zero_flag
// OPC_HALT 4'hF   halt fetch
// TIMEOUT  16     max WAIT_FLAG cycles before error
// CNT_W    16     fetch_count width
// PORTS
// CLK          in   1      rising-edge clock
// reset_n      in   1      asynchronous, active-low reset
// start        in   1      one-cycle pulse: leave IDLE, or resume from HALT
// instr        in   IW     instruction at current PC, from instruction_memory_pc
// PCSrc        out  1      to instruction_memory_pc (combinational)
// immediate    out  IMM_W  to instruction_memory_pc (combinational)
// dec_instr    out  IW     registered instruction to decode
// dec_valid    out  1      dec_instr holds an untaken instruction
// dec_ready    in   1      decode accepts dec_instr this cycle
// flag_valid   in   1      zero_flag valid this cycle
// zero_flag    in   1      result of previous instruction was zero
// halted       out  1      state==HALT
// timeout_err  out  1      sticky: BZ flag wait exceeded TIMEOUT
// fetch_count  out  CNT_W  instructions captured into slot, wraps at 2^CNT_W
// BEHAVIOUR
// Async reset: state=IDLE, dec_instr=0, dec_valid=0, timeout_err=0, fetch_count=0, wait_cnt=0.
// Hold = PCSrc=1, immediate=0. Advance = PCSrc=0, immediate=0. Branch = PCSrc=1, immediate=instr[IMM_W-1:0].
// free = !dec_valid || dec_ready. Capture = dec_instr<=instr, dec_valid<=1, fetch_count++ at the edge.
// If dec_valid && dec_ready and no capture: dec_valid<=0 at the edge.
// States:
// - IDLE: hold. On start -> FETCH. Nothing is captured.
// - FETCH, !free: hold, no capture.
// - FETCH, free, opcode other: capture, advance.
// - FETCH, free, OPC_BR: capture, branch (offset relative to the branch's own PC).
// - FETCH, free, OPC_HALT: capture, hold, -> HALT.
// - FETCH, free, OPC_BZ: hold, no capture, wait_cnt<=0, -> WAIT_FLAG.
// - WAIT_FLAG, flag_valid && free: capture BZ, PCSrc=1, immediate = zero_flag ? offset : 1, -> FETCH.
// - WAIT_FLAG, flag_valid && !free: hold and stay; flag is re-sampled the next cycle.
// - WAIT_FLAG, !flag_valid: hold, wait_cnt++. When wait_cnt reaches TIMEOUT-1: timeout_err<=1, -> HALT, BZ not captured.
// - HALT: hold, no capture. On start: timeout_err<=0, advance, -> FETCH.
// Latency: instr is seen at dec_instr one cycle after it is captured.
// Each instruction is captured exactly once. At most one PC change per cycle.
// start is ignored in FETCH and WAIT_FLAG.
// Offsets are 2's complement, sign-extended by the memory. Offset 0 on BR is a legal self-loop.
// Reset asserted mid-operation aborts immediately: dec_valid drops, and the memory PC is reset by the top.
// TESTING
// - Reset, then start; mem=0x100001..0x100004, dec_ready=1 -> dec_instr sequence 100001,100002,..; dec_valid continuous; fetch_count=4 after 4 captures.
// - dec_ready=0 for 3 cycles mid-stream -> PCSrc=1, immediate=0; dec_instr stable; no instruction lost or duplicated after release.
// - BR with offset 0xFD at PC 5 -> next captured instr from PC 2. BR with offset 0x00 -> same instr recaptured every cycle.
// - BZ at PC 3: flag_valid after 4 cycles, zero_flag=1, offset 4 -> next fetch PC 7. Repeat with zero_flag=0 -> PC 4.
// - BZ with flag_valid never asserted -> timeout_err=1 and halted=1 after TIMEOUT cycles. start -> timeout_err=0, fetch resumes at PC+1.
// - HALT instr captured -> halted=1, PC held. start -> next instr fetched. Also: reset_n low mid-WAIT_FLAG -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch sequencer for instruction_memory_pc: steers the PC each cycle and hands
// fetched instructions to decode through a one-entry valid/ready slot.
module fetch_controller #(
    parameter int         IW       = 24,
    parameter int         IMM_W    = 8,
    parameter logic [3:0] OPC_BR   = 4'hA,
    parameter logic [3:0] OPC_BZ   = 4'hB,
    parameter logic [3:0] OPC_HALT = 4'hF,
    parameter int         TIMEOUT  = 16,
    parameter int         CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [IW-1:0]    instr,
    output logic             PCSrc,
    output logic [IMM_W-1:0] immediate,
    output logic [IW-1:0]    dec_instr,
    output logic             dec_valid,
    input  logic             dec_ready,
    input  logic             flag_valid,
    input  logic             zero_flag,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_FLAG,
        HALT
    } state_t;

    state_t           state_reg, state_next;
    logic [IW-1:0]    dec_instr_reg;
    logic             dec_valid_reg, dec_valid_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] count_reg;
    logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic             capture;
    logic             free;
    logic [3:0]       opcode;
    logic [IMM_W-1:0] offset;

    assign free   = !dec_valid_reg || dec_ready;
    assign opcode = instr[IW-1 -: 4];
    assign offset = instr[IMM_W-1:0];

    // Default every cycle is "hold": PCSrc=1 with a zero offset keeps the PC put.
    always_comb begin
        state_next    = state_reg;
        PCSrc         = 1'b1;
        immediate     = '0;
        capture       = 1'b0;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (free) begin
                    if (opcode == OPC_BR) begin
                        capture   = 1'b1;
                        immediate = offset;
                    end else if (opcode == OPC_HALT) begin
                        capture    = 1'b1;
                        state_next = HALT;
                    end else if (opcode == OPC_BZ) begin
                        wait_cnt_next = '0;
                        state_next    = WAIT_FLAG;
                    end else begin
                        capture = 1'b1;
                        PCSrc   = 1'b0;
                    end
                end
            end
            WAIT_FLAG: begin
                if (flag_valid) begin
                    // A flag seen while the slot is busy is simply re-sampled next cycle.
                    if (free) begin
                        capture    = 1'b1;
                        immediate  = zero_flag ? offset : IMM_W'(1);
                        state_next = FETCH;
                    end
                end else if (wait_cnt_reg == WCW'(TIMEOUT - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCW'(1);
                end
            end
            HALT: begin
                if (start) begin
                    timeout_next = 1'b0;
                    PCSrc        = 1'b0;
                    state_next   = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (capture) begin
            dec_valid_next = 1'b1;
        end else if (dec_valid_reg && dec_ready) begin
            dec_valid_next = 1'b0;
        end else begin
            dec_valid_next = dec_valid_reg;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            dec_instr_reg <= '0;
            dec_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            count_reg     <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            dec_valid_reg <= dec_valid_next;
            timeout_reg   <= timeout_next;
            wait_cnt_reg  <= wait_cnt_next;
            if (capture) begin
                dec_instr_reg <= instr;
                count_reg     <= count_reg + CNT_W'(1);
            end
        end
    end

    assign dec_instr   = dec_instr_reg;
    assign dec_valid   = dec_valid_reg;
    assign halted      = (state_reg == HALT);
    assign timeout_err = timeout_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller with a behavioural instruction_memory_pc model,
// a per-cycle vector table, directed branch/BZ/timeout sequences and a random stream check.
module tb_fetch_controller;

    localparam int IW    = 24;
    localparam int IMM_W = 8;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             dec_ready = 1'b0;
    logic             flag_valid = 1'b0;
    logic             zero_flag = 1'b0;
    logic [IW-1:0]    instr;
    logic             PCSrc;
    logic [IMM_W-1:0] immediate;
    logic [IW-1:0]    dec_instr;
    logic             dec_valid;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] fetch_count;

    fetch_controller dut (
        .CLK(CLK), .reset_n(reset_n), .start(start), .instr(instr),
        .PCSrc(PCSrc), .immediate(immediate), .dec_instr(dec_instr),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .flag_valid(flag_valid),
        .zero_flag(zero_flag), .halted(halted), .timeout_err(timeout_err),
        .fetch_count(fetch_count)
    );

    always #5 CLK = ~CLK;

    // Memory: 256 words, 8-bit PC, so the 8-bit offset wraps exactly like sext.
    logic [7:0]    pc;
    logic [IW-1:0] mem [256];
    logic          zf_tab [256];
    assign instr = mem[pc];

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) pc <= 8'd0;
        else          pc <= PCSrc ? pc + immediate : pc + 8'd1;
    end

    logic [IW-1:0] acc [$];
    always @(posedge CLK) begin
        if (reset_n && dec_valid && dec_ready) acc.push_back(dec_instr);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic fv, input logic zf);
        start = s; dec_ready = r; flag_valid = fv; zero_flag = zf;
        @(negedge CLK);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        start = 0; dec_ready = 0; flag_valid = 0; zero_flag = 0;
        reset_n = 0;
        #1;
        acc.delete();
        repeat (2) @(posedge CLK);
        #1;
        reset_n = 1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            zf_tab[i] = 1'b0;
        end
    endtask

    task automatic load_bz_prog();
        clear_mem();
        mem[0] = 24'h100000; mem[1] = 24'h100001; mem[2] = 24'h100002;
        mem[3] = 24'hB00004; mem[4] = 24'h100044; mem[7] = 24'h100077;
    endtask

    typedef struct {
        logic        s, r, fv, zf;
        logic        ps;
        logic [7:0]  imm;
        logic        dv;
        logic [23:0] di;
        logic        h;
        logic        te;
        logic [15:0] fc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic ps, input logic [7:0] imm,
                                input logic dv, input logic [23:0] di, input logic h, input logic [15:0] fc);
        vec_t v;
        v.s = s; v.r = r; v.fv = 1'b0; v.zf = 1'b0; v.ps = ps; v.imm = imm;
        v.dv = dv; v.di = di; v.h = h; v.te = 1'b0; v.fc = fc;
        return v;
    endfunction

    task automatic bz_seq(input logic zf);
        logic [23:0] nxt;
        load_bz_prog();
        do_reset();
        drive(1, 1, 0, 0); next_cycle();
        repeat (3) begin drive(0, 1, 0, 0); next_cycle(); end
        drive(0, 1, 0, 0);
        chk("bz_detect_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("bz_detect_imm", {24'd0, immediate}, 32'd0);
        next_cycle();
        repeat (4) begin
            drive(0, 1, 0, 0);
            chk("bz_wait_imm", {24'd0, immediate}, 32'd0);
            chk("bz_wait_halted", {31'd0, halted}, 32'd0);
            next_cycle();
        end
        drive(0, 1, 1, zf);
        chk("bz_take_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("bz_take_imm", {24'd0, immediate}, zf ? 32'd4 : 32'd1);
        next_cycle();
        repeat (2) begin drive(0, 1, 0, 0); next_cycle(); end
        nxt = zf ? 24'h100077 : 24'h100044;
        chk("bz_acc_count", acc.size(), 32'd5);
        if (acc.size() == 5) begin
            chk("bz_acc_bz", {8'd0, acc[3]}, 32'hB00004);
            chk("bz_acc_target", {8'd0, acc[4]}, {8'd0, nxt});
        end
    endtask

    vec_t tbl [14];

    initial begin
        // Straight-line stream, 3-cycle stall, then HALT and resume.
        tbl[0]  = mk(1, 1, 1, 8'h00, 0, 24'h000000, 0, 0);
        tbl[1]  = mk(0, 1, 0, 8'h00, 0, 24'h000000, 0, 0);
        tbl[2]  = mk(0, 1, 0, 8'h00, 1, 24'h100001, 0, 1);
        tbl[3]  = mk(0, 1, 0, 8'h00, 1, 24'h100002, 0, 2);
        tbl[4]  = mk(0, 0, 1, 8'h00, 1, 24'h100003, 0, 3);
        tbl[5]  = mk(0, 0, 1, 8'h00, 1, 24'h100003, 0, 3);
        tbl[6]  = mk(0, 0, 1, 8'h00, 1, 24'h100003, 0, 3);
        tbl[7]  = mk(0, 1, 0, 8'h00, 1, 24'h100003, 0, 3);
        tbl[8]  = mk(0, 1, 0, 8'h00, 1, 24'h100004, 0, 4);
        tbl[9]  = mk(0, 1, 1, 8'h00, 1, 24'h100005, 0, 5);
        tbl[10] = mk(0, 1, 1, 8'h00, 1, 24'hF00000, 1, 6);
        tbl[11] = mk(1, 1, 0, 8'h00, 0, 24'hF00000, 1, 6);
        tbl[12] = mk(0, 1, 0, 8'h00, 0, 24'hF00000, 0, 6);
        tbl[13] = mk(0, 1, 0, 8'h00, 1, 24'h100007, 0, 7);

        clear_mem();
        mem[0] = 24'h100001; mem[1] = 24'h100002; mem[2] = 24'h100003; mem[3] = 24'h100004;
        mem[4] = 24'h100005; mem[5] = 24'hF00000; mem[6] = 24'h100007; mem[7] = 24'h100008;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].s, tbl[i].r, tbl[i].fv, tbl[i].zf);
            chk($sformatf("row%0d_pcsrc", i), {31'd0, PCSrc}, {31'd0, tbl[i].ps});
            chk($sformatf("row%0d_imm", i), {24'd0, immediate}, {24'd0, tbl[i].imm});
            chk($sformatf("row%0d_dv", i), {31'd0, dec_valid}, {31'd0, tbl[i].dv});
            chk($sformatf("row%0d_di", i), {8'd0, dec_instr}, {8'd0, tbl[i].di});
            chk($sformatf("row%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].h});
            chk($sformatf("row%0d_terr", i), {31'd0, timeout_err}, {31'd0, tbl[i].te});
            chk($sformatf("row%0d_fc", i), {16'd0, fetch_count}, {16'd0, tbl[i].fc});
            $display("[TB] row %0d pcsrc=%0b imm=%h dv=%0b di=%h halted=%0b fc=%0d",
                     i, PCSrc, immediate, dec_valid, dec_instr, halted, fetch_count);
            next_cycle();
        end
        begin
            logic [23:0] exp_stream [7];
            exp_stream = '{24'h100001, 24'h100002, 24'h100003, 24'h100004, 24'h100005, 24'hF00000, 24'h100007};
            chk("stream_count", acc.size(), 32'd7);
            for (int i = 0; i < 7 && i < acc.size(); i++)
                chk($sformatf("stream%0d", i), {8'd0, acc[i]}, {8'd0, exp_stream[i]});
        end

        // BR -3 at PC 5 goes back to PC 2.
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 24'h100000 + 24'(i);
        mem[5] = 24'hA000FD;
        do_reset();
        drive(1, 1, 0, 0); next_cycle();
        for (int c = 0; c < 12; c++) begin
            drive(0, 1, 0, 0);
            if (pc == 8'd5) begin
                chk("br_pcsrc", {31'd0, PCSrc}, 32'd1);
                chk("br_imm", {24'd0, immediate}, 32'hFD);
            end
            next_cycle();
        end
        chk("br_acc_count", acc.size(), 32'd11);
        if (acc.size() >= 8) begin
            chk("br_acc5", {8'd0, acc[5]}, 32'hA000FD);
            chk("br_acc6", {8'd0, acc[6]}, 32'h100002);
            chk("br_acc7", {8'd0, acc[7]}, 32'h100003);
        end
        $display("[TB] br back: %0d accepted", acc.size());

        // BR offset 0 recaptures itself every cycle.
        clear_mem();
        mem[0] = 24'hA00000;
        do_reset();
        drive(1, 1, 0, 0); next_cycle();
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, 0);
            chk("br0_pcsrc", {31'd0, PCSrc}, 32'd1);
            chk("br0_imm", {24'd0, immediate}, 32'd0);
            next_cycle();
        end
        chk("br0_fc", {16'd0, fetch_count}, 32'd6);
        chk("br0_acc_count", acc.size(), 32'd5);
        foreach (acc[i]) chk("br0_acc", {8'd0, acc[i]}, 32'hA00000);
        $display("[TB] br self-loop: fc=%0d", fetch_count);

        bz_seq(1'b1);
        $display("[TB] bz taken done");
        bz_seq(1'b0);
        $display("[TB] bz not taken done");

        // BZ timeout, then resume at PC+1.
        load_bz_prog();
        do_reset();
        drive(1, 1, 0, 0); next_cycle();
        repeat (4) begin drive(0, 1, 0, 0); next_cycle(); end
        repeat (15) begin
            drive(0, 1, 0, 0);
            chk("to_wait_halted", {31'd0, halted}, 32'd0);
            next_cycle();
        end
        drive(0, 1, 0, 0);
        chk("to_last_halted", {31'd0, halted}, 32'd0);
        chk("to_last_terr", {31'd0, timeout_err}, 32'd0);
        next_cycle();
        drive(1, 1, 0, 0);
        chk("to_halted", {31'd0, halted}, 32'd1);
        chk("to_terr", {31'd0, timeout_err}, 32'd1);
        chk("to_resume_pcsrc", {31'd0, PCSrc}, 32'd0);
        next_cycle();
        drive(0, 1, 0, 0);
        chk("to_clear_terr", {31'd0, timeout_err}, 32'd0);
        chk("to_clear_halted", {31'd0, halted}, 32'd0);
        next_cycle();
        drive(0, 1, 0, 0); next_cycle();
        chk("to_acc_count", acc.size(), 32'd4);
        if (acc.size() == 4) chk("to_acc_resume", {8'd0, acc[3]}, 32'h100044);
        $display("[TB] timeout sequence: %0d accepted", acc.size());

        // Reset pulled in the middle of WAIT_FLAG.
        load_bz_prog();
        do_reset();
        drive(1, 1, 0, 0); next_cycle();
        repeat (6) begin drive(0, 1, 0, 0); next_cycle(); end
        chk("rst_pre_fc", {16'd0, fetch_count}, 32'd3);
        #2 reset_n = 0;
        #1;
        chk("rst_dv", {31'd0, dec_valid}, 32'd0);
        chk("rst_di", {8'd0, dec_instr}, 32'd0);
        chk("rst_fc", {16'd0, fetch_count}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        chk("rst_pcsrc", {31'd0, PCSrc}, 32'd1);
        chk("rst_imm", {24'd0, immediate}, 32'd0);
        $display("[TB] async reset mid-wait checked");

        // Random program: accepted stream must follow the architectural PC walk.
        clear_mem();
        for (int i = 0; i < 256; i++) begin
            int k;
            logic [3:0] op;
            k = $urandom_range(0, 9);
            if (k < 2)      op = 4'hA;
            else if (k < 4) op = 4'hB;
            else begin
                int v;
                v = $urandom_range(0, 12);
                op = (v < 10) ? 4'(v) : 4'(v + 2);
            end
            mem[i] = {op, 20'($urandom)};
            zf_tab[i] = 1'($urandom);
        end
        do_reset();
        drive(1, 1, 0, 0); next_cycle();
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 3) != 0, zf_tab[pc]);
            next_cycle();
        end
        begin
            logic [7:0]  mpc;
            logic [23:0] w;
            mpc = 8'd0;
            chk("rand_progress", {31'd0, acc.size() > 100}, 32'd1);
            for (int i = 0; i < acc.size(); i++) begin
                w = mem[mpc];
                tests++;
                if (acc[i] !== w) begin
                    fails++;
                    $display("FAIL rand_stream[%0d]: got %h expected %h", i, acc[i], w);
                    break;
                end
                if (w[23:20] == 4'hA)      mpc = mpc + w[7:0];
                else if (w[23:20] == 4'hB) mpc = zf_tab[mpc] ? mpc + w[7:0] : mpc + 8'd1;
                else                       mpc = mpc + 8'd1;
            end
            chk("rand_count", {31'd0, (32'(fetch_count) - acc.size()) <= 1}, 32'd1);
            chk("rand_terr", {31'd0, timeout_err}, 32'd0);
            $display("[TB] random: %0d accepted, fc=%0d", acc.size(), fetch_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
